// File: rtl/sdram_cmd_pkg.sv
// Shared definitions for the SDRAM command responder: command word layout,
// field positions, wait-counter width and the controller state encoding.
package sdram_cmd_pkg;

  // Command word geometry: {we, addr[23:0], data[15:0]}
  localparam int CMD_W  = 41;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 24;

  // Field bit positions inside the command word
  localparam int WE_BIT   = 40;
  localparam int ADDR_MSB = 39;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  // Wait counter covers READ_LATENCY values 0..15
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // Split a raw FIFO word into its fields.
  function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] word);
    cmd_t c;
    c.we   = word[WE_BIT];
    c.addr = word[ADDR_MSB:ADDR_LSB];
    c.data = word[DATA_MSB:DATA_LSB];
    return c;
  endfunction

endpackage

// File: rtl/sdram_cmd_responder_if.sv
// Command-FIFO / response-FIFO / status bundle of the SDRAM command responder.
// The slave modport is the responder itself, the master modport is the side
// that owns the FIFOs.
interface sdram_cmd_responder_if;
  import sdram_cmd_pkg::*;

  logic [CMD_W-1:0]  cmd_q_i;
  logic              cmd_empty_i;
  logic              cmd_deq_o;
  logic [DATA_W-1:0] rsp_d_o;
  logic              rsp_enq_o;
  logic              rsp_full_i;
  logic              error_o;
  logic              busy_o;

  modport slave (
    input  cmd_q_i,
    input  cmd_empty_i,
    input  rsp_full_i,
    output cmd_deq_o,
    output rsp_d_o,
    output rsp_enq_o,
    output error_o,
    output busy_o
  );

  modport master (
    output cmd_q_i,
    output cmd_empty_i,
    output rsp_full_i,
    input  cmd_deq_o,
    input  rsp_d_o,
    input  rsp_enq_o,
    input  error_o,
    input  busy_o
  );

endinterface

// File: rtl/responder_ram.sv
// Single-port storage for the responder: synchronous write, registered read
// with one cycle of latency. No reset, so it maps onto block RAM; the read
// register only updates on a read, so its value is held through backpressure.
module responder_ram #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem_reg [2**ADDR_BITS];
  logic [DATA_W-1:0] rdata_reg;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_reg <= mem_reg[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sdram_cmd_responder.sv
// SDRAM command responder: pops {we, addr, data} commands from a show-ahead
// FIFO one at a time, writes or reads a 2**ADDR_BITS x 16 RAM and pushes read
// data into a response FIFO after READ_LATENCY extra wait cycles.
// Optional feature macro: SDRAM_RESPONDER_BOUNDS_CHECK_EN -- flags commands
// whose upper address bits are nonzero (sticky error_o), discards such writes
// and answers such reads with zero. Without it the upper bits simply alias.
module sdram_cmd_responder
  import sdram_cmd_pkg::*;
#(
  parameter int ADDR_BITS    = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  sdram_cmd_responder_if.slave  bus
);

  localparam int SYNC_STAGES = 2;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY);

  // Reset: asserts asynchronously, releases after SYNC_STAGES clock edges
  logic sync_reg [SYNC_STAGES];
  logic rst_n;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_rst_sync
      if (gi == 0) begin : g_first
        // First stage samples a constant one once reset is released
        always_ff @(posedge clk or negedge reset_n_i) begin
          if (!reset_n_i) sync_reg[gi] <= 1'b0;
          else            sync_reg[gi] <= 1'b1;
        end
      end else begin : g_next
        // Later stages shift the release through
        always_ff @(posedge clk or negedge reset_n_i) begin
          if (!reset_n_i) sync_reg[gi] <= 1'b0;
          else            sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rst_n = sync_reg[SYNC_STAGES-1];

  // Controller state
  state_t            state_reg, state_next;
  logic [LAT_W-1:0]  cnt_reg,   cnt_next;
  cmd_t              cmd_reg,   cmd_next;

  // RAM side
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // Handshake outputs
  logic              cmd_deq;
  logic              rsp_enq;

  // Upper address bits of the latched command, above the RAM index
  logic [ADDR_W-ADDR_BITS-1:0] addr_hi;
  logic                        drop_cmd;

  assign addr_hi = cmd_reg.addr[ADDR_W-1:ADDR_BITS];

`ifdef SDRAM_RESPONDER_BOUNDS_CHECK_EN
  logic err_reg;

  // Out-of-range commands never touch the RAM
  assign drop_cmd = |addr_hi;

  // Sticky error flag, set when an out-of-range command executes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (state_reg == ST_EXEC && drop_cmd) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.error_o = err_reg;
`else
  logic addr_hi_unused;

  // Upper bits alias onto the RAM index and are otherwise ignored
  assign addr_hi_unused = |addr_hi;
  assign drop_cmd       = 1'b0;
  assign bus.error_o    = 1'b0;
`endif

  // State, wait counter and latched command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      cmd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cmd_reg   <= cmd_next;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cmd_next   = cmd_reg;
    cmd_deq    = 1'b0;
    rsp_enq    = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // rst_n gate keeps the pop quiet while reset is held or releasing
        if (rst_n && !bus.cmd_empty_i) begin
          cmd_deq    = 1'b1;
          cmd_next   = unpack_cmd(bus.cmd_q_i);
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (cmd_reg.we) begin
          ram_we     = !drop_cmd;
          state_next = ST_IDLE;
        end else begin
          // Read is issued even when dropped so timing is identical
          ram_re     = 1'b1;
          cnt_next   = LAT_INIT;
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // At least one cycle here covers the RAM read latency
        if (cnt_reg == '0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_RESP: begin
        if (!bus.rsp_full_i) begin
          rsp_enq    = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  responder_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cmd_reg.addr[ADDR_BITS-1:0]),
    .wdata (cmd_reg.data),
    .rdata (ram_rdata)
  );

  // Response data is only driven in RESP, so it reads zero elsewhere and
  // falls to zero the instant reset forces the state back to IDLE.
  assign bus.rsp_d_o   = (state_reg == ST_RESP && !drop_cmd) ? ram_rdata : '0;
  assign bus.rsp_enq_o = rsp_enq;
  assign bus.cmd_deq_o = cmd_deq;
  assign bus.busy_o    = (state_reg != ST_IDLE);

endmodule
